// File: rtl/mpeg_mux_pkg.sv
// mpeg_mux_pkg
//   Shared definitions for the MPEG-1 program-stream muxer:
//   - state_t     : muxer FSM states
//   - start code / stream code constants
//   - timestamp prefix nibbles
//   - ts_byte()   : 5-byte marker-bit layout shared by SCR, PTS and DTS
//   - sc_byte()   : 4-byte start code (00 00 01 <code>) walker
package mpeg_mux_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PACK,
      ST_PES_SC,
      ST_PES_LEN,
      ST_STD,
      ST_PTS,
      ST_DTS,
      ST_NOTS,
      ST_PAYLOAD,
      ST_END_SC
   } state_t;

   localparam logic [23:0] START_PREFIX = 24'h000001;
   localparam logic [7:0]  PACK_CODE    = 8'hBA;
   localparam logic [7:0]  END_CODE     = 8'hB9;
   localparam logic [7:0]  NOTS_BYTE    = 8'h0F;

   // Prefix nibbles: SCR and lone PTS share 0010; PTS followed by DTS uses 0011.
   localparam logic [3:0]  PFX_SCR_PTS  = 4'b0010;
   localparam logic [3:0]  PFX_PTS_DTS  = 4'b0011;
   localparam logic [3:0]  PFX_DTS      = 4'b0001;

   // 33-bit timestamp split over five bytes with marker bits:
   // {pfx,ts[32:30],1} ts[29:22] {ts[21:15],1} ts[14:7] {ts[6:0],1}
   function automatic logic [7:0] ts_byte(input logic [3:0]  prefix,
                                          input logic [32:0] ts,
                                          input logic [2:0]  idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = {prefix, ts[32:30], 1'b1};
         3'd1:    b = ts[29:22];
         3'd2:    b = {ts[21:15], 1'b1};
         3'd3:    b = ts[14:7];
         3'd4:    b = {ts[6:0], 1'b1};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] sc_byte(input logic [7:0] code,
                                          input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = START_PREFIX[23:16];
         2'd1:    b = START_PREFIX[15:8];
         2'd2:    b = START_PREFIX[7:0];
         default: b = code;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mpeg_muxer.sv
// mpeg_muxer
//   Packetizes elementary-stream bytes into an MPEG-1 program stream.
//   Per accepted request: optional 12-byte pack header, PES start code,
//   PES length, [STD buffer field], PTS / PTS+DTS / 0x0F, payload bytes.
//   A program_end pulse queues the 00 00 01 B9 end code, emitted as soon as
//   the muxer next reaches idle (directly after a running packet).
//
// Build option:
//   MPEG_MUX_STD_BUFFER_EN - insert the 2-byte STD buffer field after the PES
//                            length (STD_SCALE / STD_SIZE parameters exist
//                            only in that build).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   pkt_start/pkt_ready     request handshake (accept = start && ready)
//   pkt_with_pack, pkt_scr  pack header enable and SCR
//   pkt_stream_id           PES stream id, passed through unchecked
//   pkt_payload_len         payload byte count
//   pkt_pts_valid/pkt_pts   presentation timestamp
//   pkt_dts_valid/pkt_dts   decoding timestamp (only with PTS)
//   es_data/es_valid/es_ready  payload byte input
//   program_end             pulse: queue program end code
//   mpeg_data/data_valid/data_ready  stream byte output
//   busy                    not idle, or end code pending
//   err_len                 one-cycle pulse: request rejected (PES length overflow)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for request or pending end code
// ST_PACK    | 12-byte pack header
// ST_PES_SC  | 00 00 01 stream_id
// ST_PES_LEN | PES length, MSB first
// ST_STD     | STD buffer field (optional build only)
// ST_PTS     | 5-byte PTS
// ST_DTS     | 5-byte DTS
// ST_NOTS    | single 0x0F (no timestamps)
// ST_PAYLOAD | payload bytes from es_data
// ST_END_SC  | 00 00 01 B9 program end code
module mpeg_muxer
   import mpeg_mux_pkg::*;
#(
   parameter logic [21:0] MUX_RATE  = 22'd3528
`ifdef MPEG_MUX_STD_BUFFER_EN
  ,parameter logic        STD_SCALE = 1'b1
  ,parameter logic [12:0] STD_SIZE  = 13'd46
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_start,
   output logic        pkt_ready,
   input  logic        pkt_with_pack,
   input  logic [32:0] pkt_scr,
   input  logic [7:0]  pkt_stream_id,
   input  logic [15:0] pkt_payload_len,
   input  logic        pkt_pts_valid,
   input  logic        pkt_dts_valid,
   input  logic [32:0] pkt_pts,
   input  logic [32:0] pkt_dts,
   input  logic [7:0]  es_data,
   input  logic        es_valid,
   output logic        es_ready,
   input  logic        program_end,
   output logic [7:0]  mpeg_data,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        busy,
   output logic        err_len
);

   state_t      state;
   logic [3:0]  idx;
   logic        end_pending;

   logic [32:0] scr_q;
   logic [32:0] pts_q;
   logic [32:0] dts_q;
   logic [7:0]  id_q;
   logic [15:0] pes_len_q;
   logic [15:0] rem_q;
   logic        pts_v_q;
   logic        dts_v_q;

   logic        can_load;
   logic        dts_eff;
   logic [4:0]  hdr_extra;
   logic [16:0] len_sum;

   logic [7:0]  cur_byte;
   logic [3:0]  last_idx;
   state_t      hdr_next;
   state_t      ts_first;
   state_t      done_state;
   state_t      after_hdr;
   logic [2:0]  ts_idx;

   assign can_load  = !data_valid || data_ready;
   assign pkt_ready = (state == ST_IDLE) && !end_pending;
   assign busy      = (state != ST_IDLE) || end_pending;
   assign es_ready  = (state == ST_PAYLOAD) && can_load;

   // DTS is only meaningful alongside a PTS.
   assign dts_eff = pkt_pts_valid && pkt_dts_valid;

   // Header bytes that follow the PES length field and count towards it.
   always_comb begin
      hdr_extra = 5'd1;
      if (pkt_pts_valid)
         hdr_extra = dts_eff ? 5'd10 : 5'd5;
`ifdef MPEG_MUX_STD_BUFFER_EN
      hdr_extra = hdr_extra + 5'd2;
`endif
   end

   // 17-bit sum so an oversize request is detected instead of wrapping.
   assign len_sum = {1'b0, pkt_payload_len} + {12'd0, hdr_extra};

   assign ts_first   = pts_v_q ? ST_PTS : ST_NOTS;
   // A program_end arriving in the same cycle as the last packet byte still
   // lands directly after it.
   assign done_state = (end_pending || program_end) ? ST_END_SC : ST_IDLE;
   assign after_hdr  = (rem_q != 16'd0) ? ST_PAYLOAD : done_state;

   // Pack bytes 4..8 carry the SCR; idx[2:0]-4 maps 4..8 onto 0..4.
   assign ts_idx = idx[2:0] - 3'd4;

   always_comb begin
      cur_byte = 8'h00;
      last_idx = 4'd0;
      hdr_next = ST_IDLE;
      case (state)
         ST_PACK: begin
            last_idx = 4'd11;
            hdr_next = ST_PES_SC;
            if (idx < 4'd4)
               cur_byte = sc_byte(PACK_CODE, idx[1:0]);
            else if (idx < 4'd9)
               cur_byte = ts_byte(PFX_SCR_PTS, scr_q, ts_idx);
            else if (idx == 4'd9)
               cur_byte = {1'b1, MUX_RATE[21:15]};
            else if (idx == 4'd10)
               cur_byte = MUX_RATE[14:7];
            else
               cur_byte = {MUX_RATE[6:0], 1'b1};
         end
         ST_PES_SC: begin
            last_idx = 4'd3;
            hdr_next = ST_PES_LEN;
            cur_byte = sc_byte(id_q, idx[1:0]);
         end
         ST_PES_LEN: begin
            last_idx = 4'd1;
`ifdef MPEG_MUX_STD_BUFFER_EN
            hdr_next = ST_STD;
`else
            hdr_next = ts_first;
`endif
            cur_byte = idx[0] ? pes_len_q[7:0] : pes_len_q[15:8];
         end
`ifdef MPEG_MUX_STD_BUFFER_EN
         ST_STD: begin
            last_idx = 4'd1;
            hdr_next = ts_first;
            cur_byte = idx[0] ? STD_SIZE[7:0] : {2'b01, STD_SCALE, STD_SIZE[12:8]};
         end
`endif
         ST_PTS: begin
            last_idx = 4'd4;
            hdr_next = dts_v_q ? ST_DTS : after_hdr;
            cur_byte = ts_byte(dts_v_q ? PFX_PTS_DTS : PFX_SCR_PTS, pts_q, idx[2:0]);
         end
         ST_DTS: begin
            last_idx = 4'd4;
            hdr_next = after_hdr;
            cur_byte = ts_byte(PFX_DTS, dts_q, idx[2:0]);
         end
         ST_NOTS: begin
            last_idx = 4'd0;
            hdr_next = after_hdr;
            cur_byte = NOTS_BYTE;
         end
         ST_END_SC: begin
            last_idx = 4'd3;
            hdr_next = ST_IDLE;
            cur_byte = sc_byte(END_CODE, idx[1:0]);
         end
         default: begin
            cur_byte = 8'h00;
            last_idx = 4'd0;
            hdr_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= 4'd0;
         end_pending <= 1'b0;
         mpeg_data   <= 8'h00;
         data_valid  <= 1'b0;
         err_len     <= 1'b0;
         scr_q       <= '0;
         pts_q       <= '0;
         dts_q       <= '0;
         id_q        <= 8'h00;
         pes_len_q   <= 16'd0;
         rem_q       <= 16'd0;
         pts_v_q     <= 1'b0;
         dts_v_q     <= 1'b0;
      end else begin
         err_len <= 1'b0;
         if (program_end)
            end_pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (can_load)
                  data_valid <= 1'b0;
               // Every sequence begins with the 00 of a start code, so the
               // first byte is loaded here without waiting a cycle.
               if (end_pending) begin
                  state <= ST_END_SC;
                  idx   <= can_load ? 4'd1 : 4'd0;
                  if (can_load) begin
                     mpeg_data  <= START_PREFIX[23:16];
                     data_valid <= 1'b1;
                  end
               end else if (pkt_start) begin
                  if (len_sum[16]) begin
                     err_len <= 1'b1;
                  end else begin
                     scr_q     <= pkt_scr;
                     pts_q     <= pkt_pts;
                     dts_q     <= pkt_dts;
                     id_q      <= pkt_stream_id;
                     pes_len_q <= len_sum[15:0];
                     rem_q     <= pkt_payload_len;
                     pts_v_q   <= pkt_pts_valid;
                     dts_v_q   <= dts_eff;
                     state     <= pkt_with_pack ? ST_PACK : ST_PES_SC;
                     idx       <= can_load ? 4'd1 : 4'd0;
                     if (can_load) begin
                        mpeg_data  <= START_PREFIX[23:16];
                        data_valid <= 1'b1;
                     end
                  end
               end
            end

            ST_PAYLOAD: begin
               if (can_load) begin
                  if (es_valid) begin
                     mpeg_data  <= es_data;
                     data_valid <= 1'b1;
                     rem_q      <= rem_q - 16'd1;
                     if (rem_q == 16'd1)
                        state <= done_state;
                  end else begin
                     data_valid <= 1'b0;
                  end
               end
            end

            default: begin
               if (can_load) begin
                  mpeg_data  <= cur_byte;
                  data_valid <= 1'b1;
                  if (idx == last_idx) begin
                     state <= hdr_next;
                     idx   <= 4'd0;
                     if (state == ST_END_SC)
                        end_pending <= 1'b0;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/mpeg_muxer.md
Name: mpeg_muxer

Overview:
- Packetizes elementary-stream bytes into an MPEG-1 system (program) stream.
- Per request, emits an optional pack header, then a PES header with PTS, PTS+DTS or no timestamps, then the payload bytes.
- Emits the program end code on request.
- Transmit counterpart of the demuxer; feeds it in loopback benches and produces re-packetized streams for the MPEG path.

Parameters:
- MUX_RATE, 22'd3528, mux_rate field in units of 50 bytes/s.
- STD_SCALE, 1'b1, STD buffer scale bit (optional feature only).
- STD_SIZE, 13'd46, STD buffer size field (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pkt_start  in  1  request strobe; accepted only when pkt_ready.
- pkt_ready  out  1  high in IDLE with no end pending.
- pkt_with_pack  in  1  prepend pack header.
- pkt_scr  in  33  SCR for pack header.
- pkt_stream_id  in  8  PES stream id (0xC0-0xCF, 0xE0-0xEF).
- pkt_payload_len  in  16  payload byte count.
- pkt_pts_valid  in  1  emit PTS.
- pkt_dts_valid  in  1  emit DTS; honoured only with pkt_pts_valid.
- pkt_pts  in  33  presentation timestamp.
- pkt_dts  in  33  decoding timestamp.
- es_data  in  8  payload byte.
- es_valid  in  1  payload byte valid.
- es_ready  out  1  payload byte consumed this cycle.
- program_end  in  1  pulse; emit 00 00 01 B9.
- mpeg_data  out  8  stream byte.
- data_valid  out  1  mpeg_data valid.
- data_ready  in  1  sink accepts byte.
- busy  out  1  not IDLE or end pending.
- err_len  out  1  one-cycle pulse; request rejected.

Behaviour:
- Reset values: data_valid=0, mpeg_data=0, es_ready=0, err_len=0, busy=0, end_pending=0, state IDLE. Reset mid-packet aborts immediately; no partial-byte completion.
- Output register load: loads when !data_valid || data_ready.
- Output hold: data_valid && !data_ready holds mpeg_data and data_valid stable.
- Request latch: request fields latched on the accept cycle N. First byte valid at N+1 with zero backpressure.
- Throughput: one byte per cycle.
- States: IDLE, PACK (12 bytes), PES_SC (00 00 01 id), PES_LEN (2 bytes, MSB first), [STD (2)], PTS (5), DTS (5), NOTS (1 byte 0x0F), PAYLOAD, END_SC (4). A byte-index counter walks the multi-byte states.
- Pack header bytes: 00 00 01 BA, {0010,scr[32:30],1}, scr[29:22], {scr[21:15],1}, scr[14:7], {scr[6:0],1}, {1,mr[21:15]}, mr[14:7], {mr[6:0],1}.
- PTS bytes: prefix nibble 0010 when alone, 0011 when DTS follows. Byte layout is the same as SCR bytes 4-8.
- DTS bytes: prefix nibble 0001.
- Without PTS: single 0x0F byte; DTS ignored.
- PES length field: payload_len + H, computed in 17 bits. H = 5 (PTS), 10 (PTS+DTS), 1 (none), +2 with STD.
- Length overflow: sum > 65535 pulses err_len on the accept cycle. Request dropped, state stays IDLE.
- PAYLOAD: es_ready = state==PAYLOAD && (!data_valid || data_ready). Each es_valid && es_ready loads es_data and decrements the remaining count. es_valid low inserts a bubble (data_valid drops).
- Payload done: after the count reaches 0, return to IDLE once the last byte is accepted. payload_len=0 returns to IDLE after the last header byte.
- program_end: latched into end_pending in any state. END_SC is emitted when IDLE is next reached, before any new request.
- Simultaneous pkt_start and program_end in IDLE: packet first, end afterwards.
- program_end while end_pending: no second end code.
- Stream ids: not checked; the id is passed through.

Optional Feature:
- MPEG_MUX_STD_BUFFER_EN defined: two bytes {01,STD_SCALE,STD_SIZE[12:8]}, STD_SIZE[7:0] are inserted after PES_LEN, before the timestamps. H += 2.
- Undefined: STD state, STD_SCALE and STD_SIZE are unused; no bytes are inserted.

Decomposition:
- Package mpeg_mux_pkg holds:
  - state enum;
  - constants START_PREFIX (00 00 01), PACK_CODE 8'hBA, END_CODE 8'hB9, NOTS_BYTE 8'h0F;
  - timestamp prefix nibbles 4'b0010, 4'b0011, 4'b0001;
  - function ts_byte(prefix, ts, idx) returning the 5-byte marker layout, shared by SCR/PTS/DTS.
- No sub-module; single module.

Test Plan:
- Pack + PTS case. Stimulus: with_pack, scr=0, id E0, pts=3600, len=3, payload AA BB CC, data_ready=1.
  Required output: 00 00 01 BA 21 00 01 00 01 80 1B 91 00 00 01 E0 00 08 21 00 01 1C 21 AA BB CC.
- PTS+DTS, no pack, id C0, pts=dts=0, len=0 -> 00 00 01 C0 00 0A 31 00 01 00 01 11 00 01 00 01; pkt_ready high next cycle.
- No timestamps, id E1, len=2 -> 00 00 01 E1 00 03 0F + 2 payload bytes.
- data_ready low 3 cycles mid-payload -> mpeg_data stable, es_ready=0, no byte lost or duplicated. es_valid gap of 2 cycles -> 2-cycle data_valid bubble.
- program_end pulsed during payload -> 00 00 01 B9 directly after the last payload byte, then busy=0.
- Error and reset:
  - len=65530 with PTS+DTS -> err_len pulse, no output.
  - Reset asserted mid-PES header -> data_valid=0 next cycle; next request produces a clean stream.
  - Loopback into the demuxer (stream_filter=0) -> decoding_timestamp=3600 from the first scenario.
